uart_tx_scheduler: RTL
======================

// Module: uart_tx_scheduler
// PURPOSE
//  Shares the single UART byte transmitter between NUM_REQ message sources
//  (e.g. DHT11 report "H:58, T:25\n\r", ultrasonic report "D:123\n\r", alarm text).
//  Grants the transmitter to one requester for a whole message (until its last byte).
//  Arbitration is round-robin; each byte is paced by the transmitter's ready handshake.
//  A stalled requester is aborted after STALL_TIMEOUT idle cycles.
// PARAMETERS
//  NUM_REQ        3          number of requesters (2..8)
//  STALL_TIMEOUT  1_000_000  max cycles in FETCH without req_valid (10 ms @ 100 MHz)
//  TO_W           20         counter width, must satisfy 2**TO_W > STALL_TIMEOUT
// PORTS
//  clk          in   1          system clock, 100 MHz
//  reset        in   1          synchronous, active-low reset
//  req_valid    in   NUM_REQ    requester i has a byte on req_data[i*8+:8]
//  req_data     in   8*NUM_REQ  packed byte per requester
//  req_last     in   NUM_REQ    byte presented by requester i ends its message
//  req_ready    out  NUM_REQ    byte of requester i is accepted this cycle
//  grant        out  NUM_REQ    one-hot owner of the transmitter, 0 when idle
//  tx_start     out  1          byte request to transmitter, held until accepted
//  tx_data      out  8          byte for transmitter, stable while tx_start=1
//  tx_ready     in   1          transmitter idle; start&&ready = byte accepted
//  busy         out  1          high in any state except IDLE
//  msg_done     out  1          1-cycle pulse: last byte of message finished
//  timeout_err  out  1          1-cycle pulse: message aborted by stall timeout
// BEHAVIOUR
//  Reset (reset==0 at clk edge): state=IDLE, rr_ptr=0, grant=0, req_ready=0,
//   tx_start=0, tx_data=8'h00, busy=0, msg_done=0, timeout_err=0, stall counter=0.
//   Reset mid-message abandons the byte silently; no msg_done or timeout_err.
//  FSM: IDLE -> FETCH -> START -> WAIT_BUSY -> WAIT_IDLE -> (FETCH | IDLE).
//  IDLE: scan req_valid from rr_ptr upward with wrap. First hit g: grant=onehot(g)
//   registered, go FETCH. Lowest scan distance wins if several are valid together.
//  FETCH: req_ready[g]=1 combinationally, all other req_ready=0.
//   On req_valid[g]: latch req_data[g] into tx_data and req_last[g] into last_q,
//   clear stall counter, go START.
//   Otherwise increment stall counter. At STALL_TIMEOUT: pulse timeout_err,
//   grant=0, rr_ptr=(g+1)%NUM_REQ, go IDLE.
//  START: tx_start=1, tx_data held. When tx_ready=1 in START: byte accepted, go WAIT_BUSY.
//  WAIT_BUSY: wait for tx_ready==0 (transmitter picked the byte up), then go WAIT_IDLE.
//  WAIT_IDLE: wait for tx_ready==1.
//   last_q=0 -> FETCH, grant is kept.
//   last_q=1 -> pulse msg_done, grant=0, rr_ptr=(g+1)%NUM_REQ, go IDLE.
//  Grant is never revoked mid-message except by timeout or reset.
//   Other requesters' valid is ignored until IDLE.
//  Latency: req_valid in IDLE at cycle t -> grant at t+1 -> byte accepted at t+1
//   if valid -> tx_start at t+2.
//  Best-case spacing between FETCH accepts is 4 cycles plus the UART frame time.
//  A 1-byte message (req_last on the first byte) is legal.
//  req_valid dropping mid-message is legal; it is only an error after STALL_TIMEOUT.
//  The stall counter counts only in FETCH; UART frame time never triggers a timeout.
// TESTING
//  1 Reset: hold reset=0 for 10 cycles with req_valid=3'b111
//    -> grant=0, tx_start=0, busy=0, req_ready=0.
//  2 Single message: req0 sends "H:58, T:25\n\r", 12 bytes, last on 8'h0D
//    -> 12 tx_start handshakes with bytes in order, exactly one msg_done, grant returns to 0.
//  3 Round-robin: req0/1/2 valid at the same cycle after reset
//    -> messages served 0,1,2. Then req0 and req2 re-request -> 0 before 2 (rr_ptr=0 after 2).
//  4 No interleave: req1 asserts valid during req0's 12-byte message
//    -> req_ready[1]=0 throughout; the tx byte stream is never mixed.
//  5 Stall: STALL_TIMEOUT=50, req2 sends "D:1" then drops valid
//    -> timeout_err pulse 50 cycles after entering FETCH, then IDLE; req0 served next.
//  6 Reset mid-message: reset=0 while in WAIT_IDLE on byte 3
//    -> all outputs at reset values next cycle; no msg_done or timeout_err pulse.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// Round-robin owner of the shared UART byte transmitter: one requester per whole message, bytes paced by tx_ready.
// Grant 1 cycle after req_valid in IDLE; tx_start holds until tx_ready; a requester idle in FETCH too long is aborted.
module uart_tx_scheduler #(
  parameter int NUM_REQ       = 3,
  parameter int STALL_TIMEOUT = 1_000_000,
  parameter int TO_W          = 20
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  input  logic                   tx_ready,
  output logic                   busy,
  output logic                   msg_done,
  output logic                   timeout_err
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_IDLE
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   g_q, g_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               last_q, last_d;
  logic [TO_W-1:0]    stall_q, stall_d;
  logic               msg_done_q, msg_done_d;
  logic               timeout_q, timeout_d;

  logic               found;
  logic [PTR_W-1:0]   hit;
  logic [PTR_W:0]     sum;
  logic               sel_valid;
  logic [7:0]         sel_data;
  logic               sel_last;
  logic [PTR_W-1:0]   g_next;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      g_q        <= '0;
      grant_q    <= '0;
      tx_data_q  <= 8'h00;
      last_q     <= 1'b0;
      stall_q    <= '0;
      msg_done_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      g_q        <= g_d;
      grant_q    <= grant_d;
      tx_data_q  <= tx_data_d;
      last_q     <= last_d;
      stall_q    <= stall_d;
      msg_done_q <= msg_done_d;
      timeout_q  <= timeout_d;
    end
  end

  // Round-robin scan starting at rr_ptr; the first hit has the lowest distance.
  always_comb begin
    found = 1'b0;
    hit   = '0;
    sum   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NUM_REQ)) sum = sum - (PTR_W+1)'(NUM_REQ);
      if (!found && req_valid[sum[PTR_W-1:0]]) begin
        found = 1'b1;
        hit   = sum[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = 8'h00;
    sel_last  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (g_q == PTR_W'(i)) begin
        sel_valid = req_valid[i];
        sel_data  = req_data[i*8 +: 8];
        sel_last  = req_last[i];
      end
    end
  end

  assign g_next = (g_q == PTR_W'(NUM_REQ-1)) ? '0 : g_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    g_d        = g_q;
    grant_d    = grant_q;
    tx_data_d  = tx_data_q;
    last_d     = last_q;
    stall_d    = stall_q;
    msg_done_d = 1'b0;
    timeout_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          g_d          = hit;
          grant_d      = '0;
          grant_d[hit] = 1'b1;
          stall_d      = '0;
          state_d      = S_FETCH;
        end
      end
      S_FETCH: begin
        if (sel_valid) begin
          tx_data_d = sel_data;
          last_d    = sel_last;
          stall_d   = '0;
          state_d   = S_START;
        end else if (stall_q == TO_W'(STALL_TIMEOUT-1)) begin
          timeout_d = 1'b1;
          grant_d   = '0;
          rr_ptr_d  = g_next;
          stall_d   = '0;
          state_d   = S_IDLE;
        end else begin
          stall_d = stall_q + 1'b1;
        end
      end
      S_START: begin
        if (tx_ready) state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!tx_ready) state_d = S_WAIT_IDLE;
      end
      S_WAIT_IDLE: begin
        if (tx_ready) begin
          if (last_q) begin
            msg_done_d = 1'b1;
            grant_d    = '0;
            rr_ptr_d   = g_next;
            state_d    = S_IDLE;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready   = (state_q == S_FETCH) ? grant_q : '0;
  assign grant       = grant_q;
  assign tx_start    = (state_q == S_START);
  assign tx_data     = tx_data_q;
  assign busy        = (state_q != S_IDLE);
  assign msg_done    = msg_done_q;
  assign timeout_err = timeout_q;

endmodule
